// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and helpers for the iterative radix-4 Booth MUL unit
//             (FSM state encoding, Booth select codes, iteration-count helper).
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Radix-4 Booth digit selections: 0, +A, +2A, -A, -2A.
  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_M2   = 3'd4
  } booth_sel_t;

  // Integer ceiling division, used to size the RUN phase.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Recode a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} into a Booth digit.
  function automatic booth_sel_t booth_decode(input logic [2:0] win);
    booth_sel_t sel;
    case (win)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_M2;
      3'b101, 3'b110: sel = SEL_M1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_pp.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r4_pp
//  Purpose  : Combinational radix-4 Booth partial-product generator. Produces
//             digit * A' shifted left by two bits per digit index.
//  Revision : 1.0  initial release
// ============================================================================
module booth_r4_pp
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDXW  = 6
) (
  input  logic [2:0]         win_i,
  input  logic [2*WIDTH+1:0] a_ext_i,
  input  logic [IDXW-1:0]    idx_i,
  output logic [2*WIDTH+1:0] pp_o
);

  localparam int PW = 2*WIDTH+2;

  booth_sel_t      w_sel;
  logic [PW-1:0]   w_mag;

  // Select the signed multiple of A' and place it at bit 2*idx.
  always_comb begin
    w_sel = booth_decode(win_i);
    case (w_sel)
      SEL_P1:  w_mag = a_ext_i;
      SEL_P2:  w_mag = a_ext_i << 1;
      SEL_M1:  w_mag = -a_ext_i;
      SEL_M2:  w_mag = -(a_ext_i << 1);
      default: w_mag = '0;
    endcase
    pp_o = w_mag << {idx_i, 1'b0};
  end

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mult_seq
//  Purpose  : Iterative radix-4 Booth multiplier, signed or unsigned per
//             operation, DIGITS_PER_CYCLE digits per clock, start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int NDIG = WIDTH/2 + 1;
  localparam int DPC  = DIGITS_PER_CYCLE;
  localparam int ITER = ceil_div(NDIG, DPC);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  // Wide enough for every digit index including last-iteration padding.
  localparam int IDXW = $clog2(ITER*DPC) + 1;
  localparam int AW   = 2*WIDTH + 2;
  localparam int BW   = WIDTH + 2;
  // Multiplier plus implicit zero below bit 0, zero-padded so every window
  // (including padding digits) stays inside the vector.
  localparam int PADW = 2*ITER*DPC + 1;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_ext_q, a_ext_d;
  logic [BW-1:0]    b_ext_q, b_ext_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic             w_accept;
  logic             w_last;
  logic [PADW-1:0]  w_bz;
  logic [AW-1:0]    w_pp [DPC];
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_acc_sum;

  assign w_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign w_last   = (count_q == CW'(ITER-1));
  assign w_bz     = PADW'({b_ext_q, 1'b0});

  // One partial-product generator per digit retired in a RUN cycle.
  for (genvar g = 0; g < DPC; g++) begin : g_digit
    logic [IDXW-1:0] w_idx;
    logic [2:0]      w_win;

    assign w_idx = IDXW'(count_q) * IDXW'(DPC) + IDXW'(g);
    // Digits past the last real one contribute nothing.
    assign w_win = (w_idx < IDXW'(NDIG)) ? w_bz[{w_idx, 1'b0} +: 3] : 3'b000;

    booth_r4_pp #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
    ) u_pp (
      .win_i   (w_win),
      .a_ext_i (a_ext_q),
      .idx_i   (w_idx),
      .pp_o    (w_pp[g])
    );
  end

  // Adder tree: sum this cycle's partial products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < DPC; i++) begin
      w_sum = w_sum + w_pp[i];
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: operand capture on accept, accumulation during RUN.
  always_comb begin
    a_ext_d   = a_ext_q;
    b_ext_d   = b_ext_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result_d  = result_q;
    w_acc_sum = acc_q + w_sum;
    if (w_accept) begin
      a_ext_d = {{(WIDTH+2){is_signed & a[WIDTH-1]}}, a};
      b_ext_d = {{2{is_signed & b[WIDTH-1]}}, b};
      acc_d   = '0;
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      acc_d   = w_acc_sum;
      count_d = count_q + 1'b1;
      if (w_last) result_d = w_acc_sum[2*WIDTH-1:0];
    end
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      a_ext_q  <= '0;
      b_ext_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_ext_q  <= a_ext_d;
      b_ext_q  <= b_ext_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mult_seq
//  Purpose  : Self-checking bench for booth_mult_seq (32-bit/1 digit and
//             8-bit/3 digits per cycle) against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_mult_seq;

  localparam int ITER32 = 17;
  localparam int ITER8  = 2;
  localparam int N8     = 2000;

  logic        clock = 1'b0;
  logic        clear, start, is_signed;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [63:0] result;

  logic        start8, sg8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8, done8;
  logic [15:0] result8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  booth_mult_seq #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) u_dut32 (
    .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  booth_mult_seq #(.WIDTH(8), .DIGITS_PER_CYCLE(3)) u_dut8 (
    .clock(clock), .clear(clear), .start(start8), .is_signed(sg8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .result(result8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sg);
    if (sg) return 64'(longint'($signed(x)) * longint'($signed(y)));
    return 64'(x) * 64'(y);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sg);
    if (sg) return 16'(int'($signed(x)) * int'($signed(y)));
    return 16'(int'(x) * int'(y));
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] corners [4];
    corners = '{8'h00, 8'h80, 8'h7F, 8'hFF};
    if ($urandom_range(0, 5) == 0) return corners[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  // One 32-bit operation; lat counts edges from the accept edge to done.
  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic sg,
                       output logic [63:0] res, output int lat);
    @(negedge clock);
    a = x; b = y; is_signed = sg; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sg;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [63:0] res, exp_a, exp_b;
    logic [31:0] x, y;
    logic        sg, hold_ok, seen;
    int          lat;
    logic [15:0] exp_q[$];
    int          cyc, last_done, ndone;

    clear = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_ready8", 64'(ready8), 64'd1);
    clear = 1'b0;

    run32(32'hFFFF_FFF9, 32'd3, 1'b1, res, lat);
    check("neg7x3", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check("latency", 64'(lat), 64'(ITER32));

    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat);
    check("umax_sq", res, 64'hFFFF_FFFE_0000_0001);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, lat);
    check("sneg1_sq", res, 64'h0000_0000_0000_0001);
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, res, lat);
    check("smin_sq", res, 64'h4000_0000_0000_0000);
    run32(32'h8000_0000, 32'h8000_0000, 1'b0, res, lat);
    check("umin_sq", res, 64'h4000_0000_0000_0000);

    for (int i = 0; i < 60; i++) begin
      x = pick32(); y = pick32(); sg = 1'($urandom);
      run32(x, y, sg, res, lat);
      check(sg ? "rand_s32" : "rand_u32", res, ref32(x, y, sg));
    end

    // start pulsed during RUN is ignored
    @(negedge clock);
    a = 32'd123456; b = 32'hFFFF_0001; is_signed = 1'b1; start = 1'b1;
    exp_a = ref32(32'd123456, 32'hFFFF_0001, 1'b1);
    @(negedge clock);
    start = 1'b0; lat = 0;
    repeat (3) begin @(negedge clock); lat++; end
    check("busy_run", 64'(busy), 64'd1);
    a = 32'h7777; b = 32'h9999; is_signed = 1'b0; start = 1'b1;
    @(negedge clock); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clock); lat++; end
    check("ign_lat", 64'(lat), 64'(ITER32));
    check("ign_res", result, exp_a);

    // start in the done cycle is accepted back-to-back
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; is_signed = 1'b1; start = 1'b1;
    exp_b = ref32(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    lat = 0; hold_ok = 1'b1;
    @(negedge clock); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin
      if (result !== exp_a) hold_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    check("b2b_gap", 64'(lat), 64'(ITER32 + 1));
    check("b2b_hold", 64'(hold_ok), 64'd1);
    check("b2b_res", result, exp_b);

    // clear while count==5 aborts the operation
    @(negedge clock);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_ready", 64'(ready), 64'd1);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_result", result, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("clr_nodone", 64'(seen), 64'd0);
    run32(32'hCAFE_0001, 32'h8000_0001, 1'b1, res, lat);
    check("clr_fresh", res, ref32(32'hCAFE_0001, 32'h8000_0001, 1'b1));

    // 8-bit, 3 digits per cycle: start held high, one product every 3 cycles
    cyc = 0; last_done = -1; ndone = 0;
    start8 = 1'b1;
    while (ndone < N8 && cyc < 3*N8 + 50) begin
      if (done8) begin
        if (exp_q.size() == 0) begin
          check("s8_unexpected_done", 64'(result8), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check(sg8 ? "s8_res" : "s8_res", 64'(result8), 64'(exp_q.pop_front()));
        end
        if (last_done >= 0) check("s8_gap", 64'(cyc - last_done), 64'(ITER8 + 1));
        last_done = cyc;
        ndone++;
      end
      if (ready8) begin
        a8 = pick8(); b8 = pick8(); sg8 = 1'($urandom);
        exp_q.push_back(ref8(a8, b8, sg8));
      end
      @(negedge clock);
      cyc++;
    end
    start8 = 1'b0;
    check("s8_count", 64'(ndone), 64'(N8));
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
